if_id_queue: RTL
================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter PC_W, default 64, width of the fetched program-counter value.
REQ-002 Parameter INSTR_W, default 32, width of the fetched instruction word.
REQ-003 Parameter DEPTH, default 2, number of entries; legal values are 2 and 4 only.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; state clears on the rising clk edge while reset=0.
REQ-006 in_valid  input  1  the fetch stage presents a valid pc/instruction pair.
REQ-007 in_pc  input  PC_W  pc of the fetched instruction.
REQ-008 in_instr  input  INSTR_W  fetched instruction word.
REQ-009 in_ready  output  1  the queue accepts a push this cycle.
REQ-010 flush  input  1  branch taken or redirect; discard all queued and incoming entries.
REQ-011 out_valid  output  1  the head entry is valid for decode.
REQ-012 out_pc  output  PC_W  pc of the head entry.
REQ-013 out_instr  output  INSTR_W  instruction of the head entry.
REQ-014 out_ready  input  1  decode consumes the head entry this cycle.
REQ-015 count  output  3  number of occupied entries, 0..DEPTH.
REQ-016 flush_cnt  output  8  saturating count of flush events that discarded at least one entry.

Function
REQ-017 The block SHALL be a circular FIFO with read pointer, write pointer and count; pointers wrap modulo DEPTH.
REQ-018 Push SHALL occur when in_valid=1, in_ready=1 and flush=0, writing {in_pc,in_instr} at wr_ptr.
REQ-019 Pop SHALL occur when out_valid=1, out_ready=1 and flush=0, advancing rd_ptr.
REQ-020 in_ready SHALL equal (count<DEPTH) and SHALL NOT depend combinationally on out_ready.
REQ-021 out_valid SHALL equal (count!=0); out_pc and out_instr SHALL show the entry at rd_ptr when out_valid=1, else all-zero.
REQ-022 Latency: a pushed entry SHALL appear at the outputs no earlier than the cycle after the push; there is no same-cycle bypass.
REQ-023 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged and move both pointers.
REQ-024 When full (count=DEPTH), in_ready=0; a pop in that cycle SHALL raise in_ready the next cycle only.
REQ-025 When empty, out_ready SHALL be ignored; count SHALL never underflow.
REQ-026 flush=1 SHALL have priority over push and pop: the next cycle has count=0, rd_ptr=wr_ptr=0 and out_valid=0, and same-cycle in_valid data is discarded.
REQ-027 flush_cnt SHALL increment by 1 when flush=1 and (count!=0 or in_valid=1), and SHALL saturate at 255.
REQ-028 Entry storage contents beyond count SHALL be don't-care, but they SHALL never be visible on the outputs.

Reset
REQ-029 With reset=0 at a clk edge, count=0, pointers=0, out_valid=0, out_pc=0, out_instr=0, in_ready=1 and flush_cnt=0 next cycle.
REQ-030 Reset SHALL override flush, push and pop; an entry in flight when reset asserts is lost.
REQ-031 Until the first clk edge with reset=0, output values are undefined; the bench SHALL apply reset for at least 2 cycles.

Verification
REQ-032 Reset, then push pc=0x0/instr=0x8B020020 in cycle 1 -> out_valid=1 and out_pc=0 in cycle 2, count=1.
REQ-033 Hold out_ready=0 and push pc 0x0, 0x4 (DEPTH=2) -> count=2, in_ready=0; a third in_valid is not accepted; with out_ready=1 the entries drain in order 0x0 then 0x4.
REQ-034 Continuous in_valid=1 and out_ready=1 with pcs 0x0, 0x4, 0x8 ... -> one entry per cycle, count stays at 1, pointers wrap with no loss or duplication over 20 entries.
REQ-035 With count=2, assert flush together with in_valid (pc 0x40) -> next cycle count=0, out_valid=0, flush_cnt=1, and pc 0x40 never appears.
REQ-036 Issue 300 flushes with a nonempty queue -> flush_cnt=255; a flush with the queue empty and in_valid=0 leaves flush_cnt unchanged.
REQ-037 Assert reset=0 with count=2 and flush=1 -> next cycle all outputs are at reset values and flush_cnt=0.

Source files
------------

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: a small circular FIFO of {pc, instr} pairs
// with flush support and a saturating count of flushes that discarded work.
module if_id_queue #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  input  logic               flush,
  output logic               out_valid,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               out_ready,
  output logic [2:0]         count,
  output logic [7:0]         flush_cnt
);

  localparam int                ENTRY_W = PC_W + INSTR_W;
  localparam int                PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]  LAST    = PTR_W'(DEPTH - 1);
  localparam logic [2:0]        DEPTH_C = 3'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [2:0]         count_q, count_d;
  logic [7:0]         flush_cnt_q, flush_cnt_d;
  logic               push, pop;

  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != 3'd0);
  assign count     = count_q;
  assign flush_cnt = flush_cnt_q;

  // Unoccupied slots hold stale data, so the head is masked when empty.
  assign out_pc    = out_valid ? mem_q[rd_ptr_q][ENTRY_W-1:INSTR_W] : '0;
  assign out_instr = out_valid ? mem_q[rd_ptr_q][INSTR_W-1:0]       : '0;

  assign push = in_valid  && in_ready  && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = 3'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {in_pc, in_instr};
        wr_ptr_d        = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      count_d = count_q + {2'b00, push} - {2'b00, pop};
    end
  end

  // Only flushes that actually threw something away are counted.
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (flush && (count_q != 3'd0 || in_valid) && flush_cnt_q != 8'hFF) begin
      flush_cnt_d = flush_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= 3'd0;
      flush_cnt_q <= 8'd0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
